// File: rtl/xif_obi_data_arbiter.sv
// xif_obi_data_arbiter
// Two-requester OBI data-port arbiter: core LSU (m0) and the eXtension
// interface coprocessor memory path (m1) share one memory data port.
// The chosen requester stays locked until its address phase is granted, and
// an in-order ID FIFO steers each response back to the requester that issued it.
// Optional feature: define XIF_OBI_ARB_RR_EN for round-robin arbitration in
// IDLE; without it m0 has fixed priority.
module xif_obi_data_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    // requester 0 (core LSU)
    input  logic                                 m0_req_i,
    output logic                                 m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                m0_addr_i,
    input  logic                                 m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]              m0_be_i,
    input  logic [DATA_WIDTH-1:0]                m0_wdata_i,
    output logic                                 m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]                m0_rdata_o,
    // requester 1 (coprocessor)
    input  logic                                 m1_req_i,
    output logic                                 m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                m1_addr_i,
    input  logic                                 m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]              m1_be_i,
    input  logic [DATA_WIDTH-1:0]                m1_wdata_i,
    output logic                                 m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]                m1_rdata_o,
    // memory data port
    output logic                                 s_req_o,
    input  logic                                 s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic                                 s_we_o,
    output logic [DATA_WIDTH/8-1:0]              s_be_o,
    output logic [DATA_WIDTH-1:0]                s_wdata_o,
    input  logic                                 s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                s_rdata_i,
    // status
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t             state, state_nxt;

    logic               win;        // IDLE arbitration result (0 = m0, 1 = m1)
    logic               sel;        // requester currently driving the address phase
    logic               sel_req;    // request of the selected requester
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               head_id;
    logic               proto_err;  // locked requester withdrew before grant
    logic               spurious;   // response with nothing outstanding

    logic [CNT_W-1:0]   occ;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic               id_mem [MAX_OUTSTANDING];
    logic               err_q;

    // Advance a FIFO pointer, wrapping at MAX_OUTSTANDING (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

`ifdef XIF_OBI_ARB_RR_EN
    logic last_gnt;  // requester granted most recently; reset to 1 so m0 wins first

    // Round-robin pick in IDLE: on contention favour whoever was not granted last.
    always_comb begin
        win = 1'b0;
        if (m0_req_i && m1_req_i) begin
            win = ~last_gnt;
        end else begin
            win = ~m0_req_i & m1_req_i;
        end
    end

    // Remember the last granted requester to rotate priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt <= 1'b1;
        end else if (push) begin
            last_gnt <= sel;
        end
    end
`else
    // Fixed-priority pick in IDLE: m0 wins whenever it requests; idle selects m0.
    always_comb begin
        win = 1'b0;
        win = ~m0_req_i & m1_req_i;
    end
`endif

    // Selection: a lock forces the mux, otherwise the arbitration winner drives it.
    always_comb begin
        sel = win;
        case (state)
            LOCK0:   sel = 1'b0;
            LOCK1:   sel = 1'b1;
            default: sel = win;
        endcase
        sel_req = sel ? m1_req_i : m0_req_i;
    end

    // A response popping this cycle frees a slot, so a full FIFO can still accept.
    assign empty = (occ == '0);
    assign full  = (occ == CNT_W'(MAX_OUTSTANDING)) && !s_rvalid_i;

    assign s_req_o   = sel_req && !full;
    assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o  = s_gnt_i && s_req_o && (sel == 1'b0);
    assign m1_gnt_o  = s_gnt_i && s_req_o && (sel == 1'b1);

    assign push      = s_req_o && s_gnt_i;
    assign pop       = s_rvalid_i && !empty;
    assign spurious  = s_rvalid_i && empty;
    assign proto_err = (state != IDLE) && !sel_req;

    assign head_id     = id_mem[rptr];
    assign m0_rvalid_o = pop && (head_id == 1'b0);
    assign m1_rvalid_o = pop && (head_id == 1'b1);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    assign outstanding_o = occ;
    assign err_o         = err_q;

    // Lock control: a stalled address phase locks its requester until granted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s_req_o && !s_gnt_i) begin
                    state_nxt = sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (push || !sel_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response-ID FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Response-ID storage; only read behind a valid pointer, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wptr] <= sel;
        end
    end

    // Sticky protocol error: spurious response or request withdrawn while locked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (spurious || proto_err) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xif_obi_data_arbiter.sv
// Testbench for xif_obi_data_arbiter: directed scenarios plus randomized
// OBI traffic, checked every cycle against a queue-based reference model.
module tb_xif_obi_data_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BEW  = DW / 8;
    localparam int MAXO = 2;
    localparam int CW   = $clog2(MAXO + 1);
`ifdef XIF_OBI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
    logic [AW-1:0]  m0_addr_i;
    logic [BEW-1:0] m0_be_i;
    logic [DW-1:0]  m0_wdata_i, m0_rdata_o;
    logic           m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
    logic [AW-1:0]  m1_addr_i;
    logic [BEW-1:0] m1_be_i;
    logic [DW-1:0]  m1_wdata_i, m1_rdata_o;
    logic           s_req_o, s_gnt_i, s_we_o, s_rvalid_i;
    logic [AW-1:0]  s_addr_o;
    logic [BEW-1:0] s_be_o;
    logic [DW-1:0]  s_wdata_o, s_rdata_i;
    logic [CW-1:0]  outstanding_o;
    logic           err_o;

    always #5 clk_i = ~clk_i;

    xif_obi_data_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i),
        .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i),
        .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o),
        .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    // Reference model: lock owner (-1 = none), queue of issuing requester IDs,
    // sticky error, last granted requester.
    int  lock_m;
    int  q[$];
    bit  err_m;
    int  last_m;
    bit  exp_g0, exp_g1;
    int  vec_cnt = 0;
    int  mis_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        lock_m = -1;
        q.delete();
        err_m  = 1'b0;
        last_m = 1;
    endtask

    task automatic zero_inputs();
        m0_req_i = 0; m0_addr_i = '0; m0_we_i = 0; m0_be_i = '0; m0_wdata_i = '0;
        m1_req_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_be_i = '0; m1_wdata_i = '0;
        s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
    endtask

    task automatic new_req(input int n);
        if (n == 0) begin
            m0_addr_i = $urandom; m0_we_i = 1'($urandom); m0_be_i = BEW'($urandom); m0_wdata_i = $urandom;
        end else begin
            m1_addr_i = $urandom; m1_we_i = 1'($urandom); m1_be_i = BEW'($urandom); m1_wdata_i = $urandom;
        end
    endtask

    // Called right after inputs change on the falling edge: compare, then
    // advance the model to what the next rising edge should produce.
    task automatic step();
        int sel, occ, head;
        bit rq_sel, sreq, full, grant;
        #1;
        occ  = q.size();
        head = (occ > 0) ? q[0] : -1;
        full = (occ == MAXO) && !s_rvalid_i;
        if (lock_m >= 0)                 sel = lock_m;
        else if (m0_req_i && m1_req_i)   sel = (RR && last_m == 0) ? 1 : 0;
        else if (m1_req_i)               sel = 1;
        else                             sel = 0;
        rq_sel = (sel == 1) ? m1_req_i : m0_req_i;
        sreq   = rq_sel && !full;
        grant  = sreq && s_gnt_i;
        exp_g0 = grant && sel == 0;
        exp_g1 = grant && sel == 1;

        check("s_req",  64'(s_req_o), 64'(sreq));
        check("m0_gnt", 64'(m0_gnt_o), 64'(exp_g0));
        check("m1_gnt", 64'(m1_gnt_o), 64'(exp_g1));
        check("s_addr", 64'(s_addr_o),  64'((sel == 1) ? m1_addr_i  : m0_addr_i));
        check("s_we",   64'(s_we_o),    64'((sel == 1) ? m1_we_i    : m0_we_i));
        check("s_be",   64'(s_be_o),    64'((sel == 1) ? m1_be_i    : m0_be_i));
        check("s_wdata",64'(s_wdata_o), 64'((sel == 1) ? m1_wdata_i : m0_wdata_i));
        check("m0_rvalid", 64'(m0_rvalid_o), 64'(s_rvalid_i && head == 0));
        check("m1_rvalid", 64'(m1_rvalid_o), 64'(s_rvalid_i && head == 1));
        if (s_rvalid_i && head == 0) check("m0_rdata", 64'(m0_rdata_o), 64'(s_rdata_i));
        if (s_rvalid_i && head == 1) check("m1_rdata", 64'(m1_rdata_o), 64'(s_rdata_i));
        check("outstanding", 64'(outstanding_o), 64'(occ));
        check("err", 64'(err_o), 64'(err_m));

        if (s_rvalid_i) begin
            if (occ == 0) err_m = 1'b1;
            else void'(q.pop_front());
        end
        if (grant) begin
            q.push_back(sel);
            last_m = sel;
        end
        if (lock_m >= 0) begin
            if (!rq_sel) begin
                err_m  = 1'b1;
                lock_m = -1;
            end else if (grant) begin
                lock_m = -1;
            end
        end else if (sreq && !s_gnt_i) begin
            lock_m = sel;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        zero_inputs();
        rst_i = 1'b1;
        #1;
        model_reset();
        check("rst_s_req", 64'(s_req_o), 64'(0));
        check("rst_outstanding", 64'(outstanding_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        zero_inputs();
        step();
    endtask

    int seq[4];
    int ng;
    bit act[2];

    initial begin
        zero_inputs();
        rst_i = 1'b1;
        model_reset();
        do_reset();
        idle_cycle();

        // Single read from m0, granted at once, response next cycle.
        @(negedge clk_i); zero_inputs();
        m0_req_i = 1; m0_addr_i = 32'h100; s_gnt_i = 1;
        step();
        check("tp1_gnt", 64'(m0_gnt_o), 64'(1));
        @(negedge clk_i); zero_inputs();
        s_rvalid_i = 1; s_rdata_i = 32'hDEADBEEF;
        step();
        check("tp1_rdata", 64'(m0_rdata_o), 64'h0000_0000_DEAD_BEEF);
        idle_cycle();

        // Lock under stall: m1 alone, m0 joins while m1 is stalled.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i); zero_inputs();
            m1_addr_i = 32'h2000; m0_addr_i = 32'h3000;
            m1_req_i  = (c <= 3);
            m0_req_i  = (c >= 1) && (c <= 4);
            s_gnt_i   = (c >= 3);
            s_rvalid_i = (q.size() > 0) && (c >= 4);
            step();
            if (c == 2) check("lock_addr", 64'(s_addr_o), 64'h2000);
        end
        while (q.size() > 0) begin
            @(negedge clk_i); zero_inputs(); s_rvalid_i = 1; s_rdata_i = $urandom; step();
        end

        // Full with a pending third request, then push/pop in the same cycle.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_i); zero_inputs();
            m0_req_i = (c == 0) || (c >= 2 && c <= 4); m0_addr_i = 32'h40 + c;
            m1_req_i = (c == 1); m1_addr_i = 32'h80;
            s_gnt_i  = 1;
            s_rvalid_i = (c == 4) || (c == 5) || (c == 6);
            s_rdata_i  = 32'h1000 + c;
            step();
            if (c == 2) check("full_blocks", 64'(s_req_o), 64'(0));
        end
        while (q.size() > 0) begin
            @(negedge clk_i); zero_inputs(); s_rvalid_i = 1; step();
        end

        // Both requesting continuously for four grants.
        ng = 0;
        for (int c = 0; c < 8 && ng < 4; c++) begin
            @(negedge clk_i); zero_inputs();
            m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'hA0; m1_addr_i = 32'hB0;
            s_gnt_i = 1; s_rvalid_i = (q.size() > 0);
            step();
            if (m0_gnt_o) begin seq[ng] = 0; ng++; end
            else if (m1_gnt_o) begin seq[ng] = 1; ng++; end
        end
        check("prio_grants", 64'(ng), 64'(4));
        for (int i = 0; i < 4; i++) check("prio_seq", 64'(seq[i]), 64'(RR ? (i % 2) : 0));
        while (q.size() > 0) begin
            @(negedge clk_i); zero_inputs(); s_rvalid_i = 1; step();
        end

        // Spurious response sets a sticky error; reset clears it.
        @(negedge clk_i); zero_inputs(); s_rvalid_i = 1; step();
        idle_cycle();
        idle_cycle();
        check("err_sticky", 64'(err_o), 64'(1));
        do_reset();
        idle_cycle();

        // Locked requester withdraws before grant.
        @(negedge clk_i); zero_inputs(); m1_req_i = 1; step();
        @(negedge clk_i); zero_inputs(); step();
        idle_cycle();
        do_reset();

        // Reset mid-transaction: a late response is an error.
        @(negedge clk_i); zero_inputs(); m0_req_i = 1; s_gnt_i = 1; step();
        do_reset();
        @(negedge clk_i); zero_inputs(); s_rvalid_i = 1; step();
        idle_cycle();
        do_reset();

        // Randomized OBI-compliant traffic.
        act[0] = 0; act[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_i);
            for (int n = 0; n < 2; n++) begin
                if (!act[n] && $urandom_range(99) < 40) begin
                    new_req(n);
                    act[n] = 1;
                end
            end
            m0_req_i   = act[0];
            m1_req_i   = act[1];
            s_gnt_i    = ($urandom_range(99) < 60);
            s_rvalid_i = (q.size() > 0) && ($urandom_range(99) < 45);
            s_rdata_i  = $urandom;
            step();
            if (exp_g0) act[0] = 0;
            if (exp_g1) act[1] = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
